cla4_word_sequencer: RTL and testbench

- Multi-cycle word adder/subtractor that time-shares one 4-bit carry-lookahead slice across a WIDTH-bit operand pair.
- Processes one nibble per clock, LSB first, and chains the slice carry-out through a carry register.
- Sits beside the ALU as a low-area add/sub unit, with a valid/ready handshake on both the request and the result side.

---
 rtl/cla4_word_sequencer_pkg.sv | 23 ++
 rtl/cla4_word_sequencer_slice.sv | 30 +++
 rtl/cla4_word_sequencer.sv | 110 +++++++++++
 tb/tb_cla4_word_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla4_word_sequencer_pkg.sv
// Shared types and constants for the nibble-serial add/sub sequencer.
package cla4_word_sequencer_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // Counter width for NSLICE passes; never narrower than one bit.
  function automatic int cnt_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cla4_word_sequencer_slice.sv
// Combinational 4-bit carry-lookahead slice with group propagate/generate.
import cla4_word_sequencer_pkg::*;

module cla4_slice (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               pg,
  output logic               gg
);
  logic [SLICE_W-1:0] p, g;
  logic [SLICE_W:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Flattened lookahead: every carry depends only on p, g and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = gg | (pg & cin);

  assign pg   = &p;
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign sum  = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];
endmodule

// File: rtl/cla4_word_sequencer.sv
// WIDTH-bit add/sub built from one CLA slice reused LSB-first, one nibble per clock.
import cla4_word_sequencer_pkg::*;

module cla4_word_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = cnt_w(NSLICE);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cla4_word_sequencer: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic [CW-1:0]      cnt_q;
  logic               carry_q;
  flags_t             flg_q;

  logic [SLICE_W-1:0] s_a, s_b, s_sum;
  logic               s_cout, last;
  logic               slice_pg_unused, slice_gg_unused;

  assign s_a  = a_q[int'(cnt_q)*SLICE_W +: SLICE_W];
  assign s_b  = b_q[int'(cnt_q)*SLICE_W +: SLICE_W];
  assign last = (cnt_q == CW'(NSLICE-1));

  cla4_slice u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout),
    .pg   (slice_pg_unused),
    .gg   (slice_gg_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      flg_q   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_q     <= op_a;
          b_q     <= op_sub ? ~op_b : op_b;
          carry_q <= op_sub;
          cnt_q   <= '0;
        end
        RUN: begin
          res_q[int'(cnt_q)*SLICE_W +: SLICE_W] <= s_sum;
          carry_q <= s_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            // MSB carry terminates here; it never wraps into slice 0.
            cnt_q      <= '0;
            flg_q.cout <= s_cout;
            flg_q.ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sum[SLICE_W-1] != a_q[WIDTH-1]);
            flg_q.zero <= ({s_sum, res_q[WIDTH-SLICE_W-1:0]} == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_q;
  assign cout      = flg_q.cout;
  assign ovf       = flg_q.ovf;
  assign zero      = flg_q.zero;
endmodule

// File: tb/tb_cla4_word_sequencer.sv
// Self-checking bench: directed corner cases plus a randomised in-order stream vs an arithmetic model.
module tb_cla4_word_sequencer;
  localparam int W   = 32;
  localparam int LAT = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, op_sub = 1'b0, res_ready = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         req_ready, res_valid, cout, ovf, zero, busy;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  cla4_word_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .cout(cout), .ovf(ovf),
    .zero(zero), .busy(busy)
  );

  // Plain integer arithmetic: unsigned for carry/borrow, signed range for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t   e;
    longint ua, ub, sa, sb, us, ss;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    us = sub ? ua - ub : ua + ub;
    ss = sub ? sa - sb : sa + sb;
    e.r = us[W-1:0];
    e.c = sub ? (ua >= ub) : (us >= 64'sh1_0000_0000);
    e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input exp_t e);
    checks++;
    if (result !== e.r || cout !== e.c || ovf !== e.v || zero !== e.z) begin
      failures++;
      $display("FAIL %s: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
               name, result, cout, ovf, zero, e.r, e.c, e.v, e.z);
    end
  endtask

  // Issue one op from IDLE, check latency and outputs, then drain it.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int   n;
    exp_t e;
    e = model(a, b, sub);
    op_a = a; op_b = b; op_sub = sub; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, n, LAT);
    end
    chk_out(name, e);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s drain: got rv=%b rr=%b busy=%b want 0 1 0", name, res_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || result !== '0 ||
        cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset: got rr=%b busy=%b rv=%b r=%h c=%b v=%b z=%b want 1 0 0 0 0 0 0",
               req_ready, busy, res_valid, result, cout, ovf, zero);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] x;
    run_op("carry_ripple", 32'hFFFF_FFFF, 32'h1, 1'b0);
    run_op("sub_borrow",   32'h5, 32'h7, 1'b1);
    run_op("ovf_add",      32'h7FFF_FFFF, 32'h1, 1'b0);
    run_op("ovf_sub",      32'h8000_0000, 32'h1, 1'b1);
    x = $urandom();
    run_op("sub_equal",    x, x, 1'b1);
    run_op("add_zero",     32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_idle_res_ready();
    logic [W-1:0] prev;
    prev = result;
    res_ready = 1'b1;
    tick(); tick();
    res_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || result !== prev) begin
      failures++;
      $display("FAIL idle_res_ready: got rr=%b rv=%b r=%h want 1 0 %h", req_ready, res_valid, result, prev);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    e = model(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    op_a = 32'h1234_5678; op_b = 32'h0FED_CBA9; op_sub = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0];
      op_a = $urandom(); op_b = $urandom(); op_sub = 1'b1;
      tick();
      checks++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got rv=%b rr=%b want 1 0", i, res_valid, req_ready);
      end
      chk_out("bp_stable", e);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got rv=%b rr=%b busy=%b want 0 1 0", res_valid, req_ready, busy);
    end
    chk_out("bp_kept", e);
  endtask

  task automatic test_mid_reset();
    op_a = 32'hDEAD_BEEF; op_b = 32'h1111_1111; op_sub = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got rr=%b rv=%b r=%h busy=%b want 1 0 0 0", req_ready, res_valid, result, busy);
    end
    // Request coincident with reset must be dropped.
    rst = 1'b1; req_valid = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_wins: got busy=%b rr=%b want 0 1", busy, req_ready);
    end
    run_op("after_reset", 32'd3, 32'd4, 1'b0);
  endtask

  task automatic test_back_to_back();
    int   got;
    bit   tmo;
    exp_t e;
    got = 0;
    tmo = 1'b0;
    fork
      begin : producer
        for (int i = 0; i < 1000; i++) begin
          int cyc;
          op_a = $urandom(); op_b = $urandom(); op_sub = $urandom_range(0, 1);
          if ($urandom_range(0, 7) == 0) op_b = op_a;
          req_valid = 1'b1;
          cyc = 0;
          while (!req_ready && cyc < 200) begin tick(); cyc++; end
          if (!req_ready) begin tmo = 1'b1; break; end
          q.push_back(model(op_a, op_b, op_sub));
          tick();
          req_valid = 1'b0;
        end
        req_valid = 1'b0;
      end
      begin : consumer
        int cyc;
        cyc = 0;
        while (got < 1000 && cyc < 60000 && !tmo) begin
          res_ready = ($urandom_range(0, 9) < 6);
          if (res_valid && res_ready) begin
            if (q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL stream: result with no pending request at op %0d", got);
            end else begin
              e = q.pop_front();
              chk_out("stream", e);
            end
            got++;
          end
          tick();
          cyc++;
        end
        res_ready = 1'b0;
      end
    join
    checks++;
    if (got !== 1000 || q.size() !== 0 || tmo) begin
      failures++;
      $display("FAIL stream_count: got %0d results, %0d pending, timeout=%b want 1000 0 0", got, q.size(), tmo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_res_ready();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
